// File: rtl/i2c_slave_regs.sv
// I2C target front end: oversamples SCL/SDA in the clk domain, detects
// START/STOP, matches a 7-bit device address and turns burst writes/reads
// into single-cycle register-bus strobes with an auto-incrementing pointer.
module i2c_slave_regs #(
  parameter logic [6:0] DEV_ADDR    = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_DEV_ADDR,
    S_DEV_ACK,
    S_REG_ADDR,
    S_REG_ACK,
    S_WR_DATA,
    S_WR_ACK,
    S_RD_DATA,
    S_RD_ACK,
    S_IGNORE
  } state_t;

  // Synchronizers and edge-detect delay flops. They reset to 1 (idle bus)
  // so that leaving reset never looks like a START.
  logic [SYNC_STAGES-1:0] scl_sync_reg;
  logic [SYNC_STAGES-1:0] sda_sync_reg;
  logic                   scl_d_reg;
  logic                   sda_d_reg;

  logic scl, sda;
  logic scl_rise, scl_fall, start_cond, stop_cond;

  // Synchronize the raw pins and keep one delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync_reg <= '1;
      sda_sync_reg <= '1;
      scl_d_reg    <= 1'b1;
      sda_d_reg    <= 1'b1;
    end else begin
      scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], scl_in};
      sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], sda_in};
      scl_d_reg    <= scl_sync_reg[SYNC_STAGES-1];
      sda_d_reg    <= sda_sync_reg[SYNC_STAGES-1];
    end
  end

  assign scl        = scl_sync_reg[SYNC_STAGES-1];
  assign sda        = sda_sync_reg[SYNC_STAGES-1];
  assign scl_rise   = scl & ~scl_d_reg;
  assign scl_fall   = ~scl & scl_d_reg;
  assign start_cond = scl & sda_d_reg & ~sda;
  assign stop_cond  = scl & ~sda_d_reg & sda;

  state_t      state_reg, state_next;
  logic [3:0]  bit_cnt_reg, bit_cnt_next;
  logic [7:0]  shift_reg, shift_next;
  logic        sda_oe_reg, sda_oe_next;
  logic [7:0]  reg_addr_reg, reg_addr_next;
  logic [7:0]  reg_wdata_reg, reg_wdata_next;
  logic        reg_we_reg, reg_we_next;
  logic        reg_re_reg, reg_re_next;
  logic        busy_reg, busy_next;
  // High in the cycle where reg_rdata answers the previous reg_re.
  logic        rd_capture_reg;

  logic       last_rise;
  logic       byte_done_fall;
  logic [7:0] byte_in;

  assign last_rise      = scl_rise && (bit_cnt_reg == 4'd7);
  assign byte_done_fall = scl_fall && (bit_cnt_reg == 4'd8);
  assign byte_in        = {shift_reg[6:0], sda};

  // State, counters and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      sda_oe_reg     <= 1'b0;
      reg_addr_reg   <= '0;
      reg_wdata_reg  <= '0;
      reg_we_reg     <= 1'b0;
      reg_re_reg     <= 1'b0;
      busy_reg       <= 1'b0;
      rd_capture_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      sda_oe_reg     <= sda_oe_next;
      reg_addr_reg   <= reg_addr_next;
      reg_wdata_reg  <= reg_wdata_next;
      reg_we_reg     <= reg_we_next;
      reg_re_reg     <= reg_re_next;
      busy_reg       <= busy_next;
      rd_capture_reg <= reg_re_reg;
    end
  end

  // Next state, bit counter and shifter; START beats everything, then STOP
  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    if (start_cond) begin
      state_next   = S_DEV_ADDR;
      bit_cnt_next = '0;
    end else if (stop_cond) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_DEV_ADDR, S_REG_ADDR, S_WR_DATA: begin
          if (scl_rise && (bit_cnt_reg != 4'd8)) begin
            shift_next   = byte_in;
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end else if (byte_done_fall) begin
            if (state_reg == S_DEV_ADDR)
              state_next = (shift_reg[7:1] == DEV_ADDR) ? S_DEV_ACK : S_IGNORE;
            else if (state_reg == S_REG_ADDR)
              state_next = S_REG_ACK;
            else
              state_next = S_WR_ACK;
          end
        end
        S_DEV_ACK: begin
          if (scl_fall) begin
            state_next   = shift_reg[0] ? S_RD_DATA : S_REG_ADDR;
            bit_cnt_next = '0;
          end
        end
        S_REG_ACK, S_WR_ACK: begin
          if (scl_fall) begin
            state_next   = S_WR_DATA;
            bit_cnt_next = '0;
          end
        end
        S_RD_DATA: begin
          if (rd_capture_reg) begin
            shift_next   = reg_rdata;
            bit_cnt_next = '0;
          end else if (scl_fall) begin
            if (bit_cnt_reg == 4'd7) begin
              state_next = S_RD_ACK;
            end else begin
              shift_next   = {shift_reg[6:0], 1'b0};
              bit_cnt_next = bit_cnt_reg + 4'd1;
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise && sda)
            state_next = S_IGNORE;
          else if (scl_fall)
            state_next = S_RD_DATA;
        end
        default: ;
      endcase
    end
  end

  // Output values: SDA drive, register pointer, write data and strobes
  always_comb begin
    sda_oe_next    = sda_oe_reg;
    reg_addr_next  = reg_addr_reg;
    reg_wdata_next = reg_wdata_reg;
    reg_we_next    = 1'b0;
    reg_re_next    = 1'b0;
    busy_next      = busy_reg;
    // The pointer steps the cycle after each write strobe, even if a
    // START/STOP lands in that same cycle.
    if (reg_we_reg)
      reg_addr_next = reg_addr_reg + 8'd1;
    if (start_cond) begin
      busy_next   = 1'b1;
      sda_oe_next = 1'b0;
    end else if (stop_cond) begin
      busy_next   = 1'b0;
      sda_oe_next = 1'b0;
    end else begin
      case (state_reg)
        S_DEV_ADDR: begin
          if (byte_done_fall && (shift_reg[7:1] == DEV_ADDR))
            sda_oe_next = 1'b1;
        end
        S_REG_ADDR: begin
          if (last_rise)
            reg_addr_next = byte_in;
          if (byte_done_fall)
            sda_oe_next = 1'b1;
        end
        S_WR_DATA: begin
          if (last_rise) begin
            reg_wdata_next = byte_in;
            reg_we_next    = 1'b1;
          end
          if (byte_done_fall)
            sda_oe_next = 1'b1;
        end
        S_DEV_ACK: begin
          if (scl_fall) begin
            sda_oe_next = 1'b0;
            reg_re_next = shift_reg[0];
          end
        end
        S_REG_ACK, S_WR_ACK: begin
          if (scl_fall)
            sda_oe_next = 1'b0;
        end
        S_RD_DATA: begin
          // First bit goes out as soon as the read data arrives; later
          // bits follow each SCL fall.
          if (rd_capture_reg) begin
            sda_oe_next = ~reg_rdata[7];
          end else if (scl_fall) begin
            if (bit_cnt_reg == 4'd7) begin
              sda_oe_next   = 1'b0;
              reg_addr_next = reg_addr_reg + 8'd1;
            end else begin
              sda_oe_next = ~shift_reg[6];
            end
          end
        end
        S_RD_ACK: begin
          // Still here at the fall means the master ACKed: fetch the next byte.
          if (scl_fall)
            reg_re_next = 1'b1;
        end
        default: sda_oe_next = 1'b0;
      endcase
    end
  end

  assign sda_oe    = sda_oe_reg;
  assign reg_addr  = reg_addr_reg;
  assign reg_wdata = reg_wdata_reg;
  assign reg_we    = reg_we_reg;
  assign reg_re    = reg_re_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: bit-banged I2C master, simple register file
// returning addr^0xFF, and scoreboards of expected register-bus strobes.
`timescale 1ns/1ps
module tb_i2c_slave_regs;

  localparam int H = 100;  // SCL half period in ns (10 clk periods)

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata = 8'h00;
  logic       busy;

  always #5 clk = ~clk;

  // Open-drain wired-AND of master and target
  assign sda_line = sda_m & ~sda_oe;

  i2c_slave_regs #(.DEV_ADDR(7'h42), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (scl_m),
    .sda_in    (sda_line),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  // Register file model: data = address ^ 0xFF, one cycle after reg_re
  always @(posedge clk) begin
    if (reg_re) reg_rdata <= reg_addr ^ 8'hFF;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboards: {addr,data} for writes, addr for reads
  logic [15:0] wq[$];
  logic [7:0]  rq[$];
  logic        oe_seen = 1'b0;
  logic        we_prev = 1'b0;
  logic        re_prev = 1'b0;

  // Monitor: pop and compare each strobe the DUT produces
  always @(negedge clk) begin
    if (!reset) begin
      if (sda_oe) oe_seen = 1'b1;
      if (reg_we) begin
        $display("reg_we addr=%02h data=%02h", reg_addr, reg_wdata);
        check("we_re_excl", reg_re, 0);
        check("we_one_cycle", we_prev, 0);
        if (wq.size() == 0) check("unexpected_we", reg_we, 0);
        else begin
          logic [15:0] e;
          e = wq.pop_front();
          check("we_addr", reg_addr, e[15:8]);
          check("we_data", reg_wdata, e[7:0]);
        end
      end
      if (reg_re) begin
        $display("reg_re addr=%02h", reg_addr);
        check("re_one_cycle", re_prev, 0);
        if (rq.size() == 0) check("unexpected_re", reg_re, 0);
        else check("re_addr", reg_addr, rq.pop_front());
      end
    end
    we_prev = reg_we;
    re_prev = reg_re;
  end

  // One SCL clock: entered just after an SCL fall, returns after the next fall
  task automatic bit_io(input logic b, output logic r);
    #(H/2); sda_m = b;
    #(H/2); scl_m = 1'b1;
    #(H/2); r = sda_line;
    #(H/2); scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    #(H/2); sda_m = 1'b1;
    #(H/2); scl_m = 1'b1;
    #(H);   sda_m = 1'b0;
    #(H);   scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    #(H/2); sda_m = 1'b0;
    #(H/2); scl_m = 1'b1;
    #(H);   sda_m = 1'b1;
    #(H);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_io(d[i], r);
    bit_io(1'b1, r);
    ack = ~r;
    $display("master wrote %02h ack=%0b", d, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, r);
      d[i] = r;
    end
    bit_io(nack, r);
    $display("master read %02h nack=%0b", d, nack);
  endtask

  task automatic settle();
    repeat (6) @(negedge clk);
  endtask

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic       ack;
    logic [7:0] d;
    logic [7:0] wr_data[3];

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_reg_addr", reg_addr, 0);
    check("rst_reg_wdata", reg_wdata, 0);
    check("rst_we_re", {reg_we, reg_re}, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    settle();

    // Burst write 0x10: A5 5A 3C
    wr_data[0] = 8'hA5; wr_data[1] = 8'h5A; wr_data[2] = 8'h3C;
    for (int k = 0; k < 3; k++) wq.push_back({8'h10 + 8'(k), wr_data[k]});
    i2c_start();
    @(negedge clk);
    check("t1_busy", busy, 1);
    write_byte(8'h84, ack); check("t1_ack_dev", ack, 1);
    write_byte(8'h10, ack); check("t1_ack_reg", ack, 1);
    for (int k = 0; k < 3; k++) begin
      write_byte(wr_data[k], ack);
      check("t1_ack_data", ack, 1);
    end
    i2c_stop();
    settle();
    check("t1_final_addr", reg_addr, 8'h13);
    check("t1_busy_after", busy, 0);
    check("t1_wq_empty", wq.size(), 0);

    // Burst read of 4 from 0x20, NACK on the last
    i2c_start();
    write_byte(8'h84, ack); check("t2_ack_dev", ack, 1);
    write_byte(8'h20, ack); check("t2_ack_reg", ack, 1);
    i2c_stop();
    for (int k = 0; k < 4; k++) rq.push_back(8'h20 + 8'(k));
    i2c_start();
    write_byte(8'h85, ack); check("t2_ack_rd", ack, 1);
    for (int k = 0; k < 4; k++) begin
      read_byte(k == 3, d);
      check("t2_rd_byte", d, (8'h20 + 8'(k)) ^ 8'hFF);
    end
    i2c_stop();
    settle();
    check("t2_rq_empty", rq.size(), 0);
    check("t2_final_addr", reg_addr, 8'h24);

    // Address mismatch: 0x43 never ACKed, no strobes
    oe_seen = 1'b0;
    i2c_start();
    write_byte(8'h86, ack); check("t3_nack_dev", ack, 0);
    write_byte(8'h11, ack);
    write_byte(8'h22, ack);
    i2c_stop();
    settle();
    check("t3_oe_never", oe_seen, 0);
    check("t3_addr_kept", reg_addr, 8'h24);

    // Pointer wrap from 0xFE
    wq.push_back({8'hFE, 8'h01});
    wq.push_back({8'hFF, 8'h02});
    wq.push_back({8'h00, 8'h03});
    i2c_start();
    write_byte(8'h84, ack);
    write_byte(8'hFE, ack);
    for (int k = 1; k <= 3; k++) begin
      write_byte(8'(k), ack);
      check("t4_ack_data", ack, 1);
    end
    i2c_stop();
    settle();
    check("t4_final_addr", reg_addr, 8'h01);
    check("t4_wq_empty", wq.size(), 0);

    // Repeated START: set pointer 0x05, then read one byte
    rq.push_back(8'h05);
    i2c_start();
    write_byte(8'h84, ack);
    write_byte(8'h05, ack); check("t5_ack_reg", ack, 1);
    i2c_start();
    write_byte(8'h85, ack); check("t5_ack_rd", ack, 1);
    read_byte(1'b1, d);
    check("t5_rd_byte", d, 8'hFA);
    i2c_stop();
    settle();
    check("t5_rq_empty", rq.size(), 0);
    check("t5_final_addr", reg_addr, 8'h06);

    // Reset during bit 4 of a data byte
    i2c_start();
    write_byte(8'h84, ack);
    write_byte(8'h30, ack);
    for (int i = 7; i >= 5; i--) begin
      logic r;
      bit_io(d[0] | 1'b1, r);
    end
    #(H/2); sda_m = 1'b1;
    #(H/2); scl_m = 1'b1;
    @(negedge clk);
    check("t6_ptr_pre", reg_addr, 8'h30);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_sda_oe", sda_oe, 0);
    check("t6_reg_addr", reg_addr, 0);
    check("t6_busy", busy, 0);
    #(H/2); scl_m = 1'b0;
    i2c_stop();
    settle();
    wq.push_back({8'h31, 8'h77});
    i2c_start();
    write_byte(8'h84, ack); check("t6_ack_dev", ack, 1);
    write_byte(8'h31, ack);
    write_byte(8'h77, ack); check("t6_ack_data", ack, 1);
    i2c_stop();
    settle();
    check("t6_final_addr", reg_addr, 8'h32);
    check("t6_wq_empty", wq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/i2c_slave_regs.md
Name: i2c_slave_regs

Overview:
- I2C target (slave) front end of the FPGA; it is the device the bench I2C master drives.
- Oversamples SCL/SDA in the system clock domain, detects START/STOP, and matches a 7-bit device address.
- Converts I2C burst writes and reads into single-cycle register-bus strobes, with an auto-incrementing 8-bit register pointer.
- Feeds the register file that sits downstream.

Parameters:
- DEV_ADDR, 7'h42, 7-bit I2C device address this block ACKs.
- SYNC_STAGES, 2, synchronizer flops on scl_in/sda_in (minimum 2).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- scl_in  input  1  raw SCL pin level (asynchronous).
- sda_in  input  1  raw SDA pin level (asynchronous).
- sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
- reg_addr  output  8  register pointer presented to the register file.
- reg_wdata  output  8  write data; valid while reg_we=1.
- reg_we  output  1  one-cycle write strobe.
- reg_re  output  1  one-cycle read strobe.
- reg_rdata  input  8  read data; valid the cycle after reg_re.
- busy  output  1  1 from START to STOP.

Behaviour:
- Clock and reset: single domain on clk. Reset is synchronous, active-high.
- Reset values: sda_oe=0, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, busy=0, state=IDLE, shift register=0, bit counter=0.
- Input sync and timing:
  - scl_in and sda_in each pass through SYNC_STAGES flops, plus one delay flop for edge detection.
  - Required timing: SCL high and SCL low phases each last at least 4 clk periods. SDA is stable for at least 2 clk periods before an SCL rise.
- Bus conditions:
  - START = synced SDA falls while synced SCL is 1. STOP = synced SDA rises while synced SCL is 1.
  - Data bits are sampled on the synced SCL rising edge, MSB first.
  - sda_oe changes only in the cycle after a synced SCL falling edge, or on START/STOP.
- STOP, from any state: go to IDLE, sda_oe=0, busy=0. The pointer is kept.
- START, from any state (this includes a repeated START): go to DEV_ADDR, bit counter=0, busy=1, sda_oe=0.
- IDLE: wait for START.
- DEV_ADDR: shift 8 bits.
  - Upper 7 bits == DEV_ADDR: go to DEV_ACK.
  - Otherwise: go to IGNORE, sda_oe never asserted.
- DEV_ACK: assert sda_oe from the falling edge after bit 8 until the next falling edge.
  - R/W=0: go to REG_ADDR.
  - R/W=1: pulse reg_re at the ACK falling edge, capture reg_rdata into the shifter next cycle, go to RD_DATA.
- REG_ADDR: shift 8 bits, load them into the pointer (reg_addr), then REG_ACK (ACK as above), then WR_DATA.
- WR_DATA: shift 8 bits.
  - Cycle after the 8th rising edge: reg_wdata=byte, reg_we=1 for one cycle with reg_addr=pointer.
  - Next cycle: pointer += 1, mod 256, so 8'hFF wraps to 8'h00.
  - Then WR_ACK (ACK), then WR_DATA.
- RD_DATA: drive bit 7..0 of the shifter.
  - Each bit is set up after an SCL falling edge. sda_oe = ~bit.
  - After the 8th falling edge: release SDA, pointer += 1 (wraps), go to RD_ACK.
- RD_ACK: sample SDA on the SCL rising edge.
  - 0 (ACK): pulse reg_re at the following falling edge with the new pointer, capture the data, go to RD_DATA.
  - 1 (NACK): go to IGNORE, no further reg_re.
- IGNORE: sda_oe=0; wait for START or STOP.
- reg_we and reg_re are never both 1. Each is exactly 1 cycle per byte.
- Simultaneous START and data edge: START wins.
- Reset mid-transfer: all outputs return to reset values in the next cycle and SDA is released. A subsequent bus STOP is harmless.

Test Plan:
- Burst write: dev 0x42 W, reg 0x10, data 0xA5,0x5A,0x3C, STOP -> three reg_we pulses at reg_addr 0x10/0x11/0x12 with those data; ACK on all 5 bytes; final reg_addr=0x13, busy=0.
- Burst read: write reg 0x20 + STOP, then START 0x42 R, read 4 with NACK on the last; register file returns addr^0xFF -> bytes 0xDF,0xDE,0xDD,0xDC; exactly 4 reg_re pulses.
- Address mismatch: START 0x43 W, 2 bytes, STOP -> sda_oe stays 0 for the whole transfer, no reg_we/reg_re.
- Pointer wrap: write reg 0xFE, data 0x01,0x02,0x03 -> writes land at 0xFE,0xFF,0x00; final reg_addr=0x01.
- Repeated START: 0x42 W, reg 0x05, then Sr 0x42 R, read 1 with NACK -> one reg_re at 0x05, no reg_we.
- Reset mid-byte: assert reset during bit 4 of a write data byte -> sda_oe=0 and reg_addr=0 next cycle, no reg_we; the next clean transfer succeeds.
